// File: rtl/adder_bist_pkg.sv
// Shared types and constants for the adder BIST driver/checker.
// Case vector is {carry_in, b, a}.
package adder_bist_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      CHECK,
      DONE
   } state_t;

   localparam int NUM_CASE_BITS = 17;
   localparam int ERR_CNT_BITS  = 18;

   localparam logic [NUM_CASE_BITS-1:0] LAST_CASE = 17'h1FFFF;

endpackage

// File: rtl/adder_bist_flex_counter.sv
// Up-counter with synchronous clear; flags when count equals rollover_val.
// Wraps to zero after the rollover value.
module flex_counter #(
   parameter int NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    count_enable,
   input  logic [NUM_CNT_BITS-1:0] rollover_val,
   output logic                    rollover_flag
);

   logic [NUM_CNT_BITS-1:0] count;

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (count_enable) begin
         if (count == rollover_val) begin
            count <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

   assign rollover_flag = (count == rollover_val);

endmodule

// File: rtl/adder_bist_8bit.sv
// Exhaustive self-test sweep for the adder: drives every {cin,b,a} case,
// waits the settle time, then checks sum/overflow against a 9-bit golden sum.
module adder_bist_8bit
   import adder_bist_pkg::*;
#(
   parameter int NUM_BITS      = 8,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    start,
   output logic [NUM_BITS-1:0]     a_out,
   output logic [NUM_BITS-1:0]     b_out,
   output logic                    carry_in_out,
   input  logic [NUM_BITS-1:0]     sum_in,
   input  logic                    overflow_in,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic [ERR_CNT_BITS-1:0] error_count,
   output logic                    first_fail_valid,
   output logic [2*NUM_BITS:0]     first_fail_case
);

   localparam int CW = 2 * NUM_BITS + 1;
   localparam int TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = '1;

   state_t          state;
   logic [CW-1:0]   case_q;
   logic [NUM_BITS:0] golden;
   logic            mismatch;
   logic            settle_done;

   assign a_out        = case_q[NUM_BITS-1:0];
   assign b_out        = case_q[2*NUM_BITS-1:NUM_BITS];
   assign carry_in_out = case_q[2*NUM_BITS];

   // Full-width sum so the carry out is compared, not dropped.
   assign golden = {1'b0, a_out}
                 + {1'b0, b_out}
                 + {{NUM_BITS{1'b0}}, carry_in_out};

   assign mismatch = (golden[NUM_BITS-1:0] != sum_in)
                  || (golden[NUM_BITS] != overflow_in);

   flex_counter #(
      .NUM_CNT_BITS(TW)
   ) u_settle (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (state != SETTLE),
      .count_enable (state == SETTLE),
      .rollover_val (TW'(SETTLE_CYCLES - 1)),
      .rollover_flag(settle_done)
   );

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state            <= IDLE;
         case_q           <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         error_count      <= '0;
         first_fail_valid <= 1'b0;
         first_fail_case  <= '0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  state            <= SETTLE;
                  case_q           <= '0;
                  error_count      <= '0;
                  first_fail_valid <= 1'b0;
                  done             <= 1'b0;
                  pass             <= 1'b0;
                  busy             <= 1'b1;
               end
            end
            SETTLE: begin
               if (settle_done) begin
                  state <= CHECK;
               end
            end
            CHECK: begin
               if (mismatch) begin
                  if (error_count != '1) begin
                     error_count <= error_count + 1'b1;
                  end
                  if (!first_fail_valid) begin
                     first_fail_valid <= 1'b1;
                     first_fail_case  <= case_q;
                  end
               end
               // Terminal test precedes the increment so the sweep never wraps.
               if (case_q == LAST) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (error_count == '0) && !mismatch;
               end else begin
                  case_q <= case_q + 1'b1;
                  state  <= SETTLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adder_bist_8bit.sv
// Randomized bench for adder_bist_8bit at reduced width, settle 1 and 3,
// against a sweep-level model of expected outputs.
module tb_adder_bist_8bit;

   localparam int NB    = 4;
   localparam int CW    = 2 * NB + 1;
   localparam int NC    = 1 << CW;
   localparam int LASTC = NC - 1;
   localparam int TMO   = 5000;

   logic clk   = 1'b0;
   logic n_rst = 1'b0;
   logic start = 1'b0;

   logic [NB-1:0] d1_a, d1_b, d1_sum;
   logic [NB-1:0] d3_a, d3_b, d3_sum;
   logic          d1_cin, d1_ovf, d1_busy, d1_done, d1_pass, d1_ffv;
   logic          d3_cin, d3_ovf, d3_busy, d3_done, d3_pass, d3_ffv;
   logic [17:0]   d1_err, d3_err;
   logic [CW-1:0] d1_ffc, d3_ffc;

   int mode  = 0;
   int fcase = 0;
   int fmask = 1;
   int checks = 0;
   int errors = 0;

   int d1_p1 = 0, d1_p2 = 0, d3_p1 = 0, d3_p2 = 0;
   int d1_res, d3_res;

   int ph[2];
   int mm[2];
   int first[2];
   int cum[2][NC];

   always #5 clk = ~clk;

   function automatic int gold(int c);
      int m;
      m = (1 << NB) - 1;
      return (c & m) + ((c >> NB) & m) + ((c >> (2 * NB)) & 1);
   endfunction

   // Adder under test: 0 good, 1 sum[0] stuck 0, 2 no carry out, 4 one bad case.
   function automatic int adder_out(int md, int c, int fc, int fm);
      int g;
      g = gold(c);
      case (md)
         1: return g & ((1 << (NB + 1)) - 2);
         2: return g & ((1 << NB) - 1);
         4: return (c == fc) ? (g ^ fm) : g;
         default: return g;
      endcase
   endfunction

   always @(posedge clk) begin
      d1_p1 <= int'({d1_cin, d1_b, d1_a});
      d1_p2 <= d1_p1;
      d3_p1 <= int'({d3_cin, d3_b, d3_a});
      d3_p2 <= d3_p1;
   end

   assign d1_res = adder_out((mode == 3) ? 0 : mode,
                             (mode == 3) ? d1_p2 : int'({d1_cin, d1_b, d1_a}),
                             fcase, fmask);
   assign d3_res = adder_out((mode == 3) ? 0 : mode,
                             (mode == 3) ? d3_p2 : int'({d3_cin, d3_b, d3_a}),
                             fcase, fmask);
   assign d1_sum = d1_res[NB-1:0];
   assign d1_ovf = d1_res[NB];
   assign d3_sum = d3_res[NB-1:0];
   assign d3_ovf = d3_res[NB];

   adder_bist_8bit #(.NUM_BITS(NB), .SETTLE_CYCLES(1)) u1 (
      .clk(clk), .n_rst(n_rst), .start(start),
      .a_out(d1_a), .b_out(d1_b), .carry_in_out(d1_cin),
      .sum_in(d1_sum), .overflow_in(d1_ovf),
      .busy(d1_busy), .done(d1_done), .pass(d1_pass),
      .error_count(d1_err), .first_fail_valid(d1_ffv),
      .first_fail_case(d1_ffc)
   );

   adder_bist_8bit #(.NUM_BITS(NB), .SETTLE_CYCLES(3)) u3 (
      .clk(clk), .n_rst(n_rst), .start(start),
      .a_out(d3_a), .b_out(d3_b), .carry_in_out(d3_cin),
      .sum_in(d3_sum), .overflow_in(d3_ovf),
      .busy(d3_busy), .done(d3_done), .pass(d3_pass),
      .error_count(d3_err), .first_fail_valid(d3_ffv),
      .first_fail_case(d3_ffc)
   );

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Per-case outcome of a whole sweep; a lagging adder shows the case
   // that was on its inputs two cycles before the check.
   task automatic build(int d, int prevc);
      int s;
      int acc;
      s = d ? 3 : 1;
      acc = 0;
      first[d] = -1;
      for (int k = 0; k < NC; k++) begin
         int inc;
         int j;
         inc = k;
         if (mode == 3) begin
            j = k * (s + 1) + s - 2;
            inc = (j < 0) ? prevc : j / (s + 1);
         end
         if (adder_out((mode == 3) ? 0 : mode, inc, fcase, fmask) != gold(k)) begin
            acc++;
            if (first[d] < 0) first[d] = k;
         end
         cum[d][k] = acc;
      end
   endtask

   task automatic cmp_dut(int d, logic [CW-1:0] c, logic b, logic dn,
                          logic p, logic [17:0] e, logic fv,
                          logic [CW-1:0] fc);
      int s;
      int nchk;
      int ec, ee, eb, ed, ep, efv;
      string u;
      s = d ? 3 : 1;
      u = d ? "u3" : "u1";
      ec = 0; ee = 0; eb = 0; ed = 0; ep = 0; efv = 0;
      case (ph[d])
         1: begin
            nchk = mm[d] / (s + 1);
            ec  = nchk;
            ee  = (nchk > 0) ? cum[d][nchk-1] : 0;
            eb  = 1;
            efv = (first[d] >= 0 && first[d] < nchk) ? 1 : 0;
         end
         2: begin
            ec  = LASTC;
            ee  = cum[d][LASTC];
            ed  = 1;
            ep  = (ee == 0) ? 1 : 0;
            efv = (first[d] >= 0) ? 1 : 0;
         end
         default: ;
      endcase
      chk({u, ".case"}, c, ec);
      chk({u, ".busy"}, b, eb);
      chk({u, ".done"}, dn, ed);
      chk({u, ".pass"}, p, ep);
      chk({u, ".error_count"}, e, ee);
      chk({u, ".first_fail_valid"}, fv, efv);
      if (ph[d] == 0) chk({u, ".first_fail_case"}, fc, 0);
      else if (efv == 1) chk({u, ".first_fail_case"}, fc, first[d]);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         ph[d] = 0;
         mm[d] = 0;
         first[d] = -1;
      end
      forever begin
         @(posedge clk);
         for (int d = 0; d < 2; d++) begin
            int s;
            s = d ? 3 : 1;
            if (!n_rst) begin
               ph[d] = 0;
            end else if (ph[d] == 1) begin
               mm[d]++;
               if (mm[d] == NC * (s + 1)) ph[d] = 2;
            end else if (start) begin
               build(d, (ph[d] == 2) ? LASTC : 0);
               ph[d] = 1;
               mm[d] = 0;
            end
         end
         @(negedge clk);
         cmp_dut(0, {d1_cin, d1_b, d1_a}, d1_busy, d1_done, d1_pass,
                 d1_err, d1_ffv, d1_ffc);
         cmp_dut(1, {d3_cin, d3_b, d3_a}, d3_busy, d3_done, d3_pass,
                 d3_err, d3_ffv, d3_ffc);
      end
   end

   task automatic wait_done(output int t1, output int t3);
      int n;
      n = 0;
      t1 = -1;
      t3 = -1;
      while (!(d1_done === 1'b1 && d3_done === 1'b1) && n < TMO) begin
         @(negedge clk);
         n++;
         if (d1_done === 1'b1 && t1 < 0) t1 = n;
         if (d3_done === 1'b1 && t3 < 0) t3 = n;
      end
      chk("sweep_end_u1", d1_done, 1);
      chk("sweep_end_u3", d3_done, 1);
   endtask

   task automatic run_sweep(output int t1, output int t3);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start_u1", d1_busy, 1);
      chk("busy_after_start_u3", d3_busy, 1);
      wait_done(t1, t3);
   endtask

   initial begin
      int t1, t3, n;
      repeat (3) @(negedge clk);
      n_rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_busy", d1_busy, 0);
      chk("reset_a", d3_a, 0);
      chk("reset_err", d1_err, 0);

      mode = 0;
      run_sweep(t1, t3);
      chk("len_u1", t1, NC * 2);
      chk("len_u3", t3, NC * 4);
      chk("good_pass_u1", d1_pass, 1);
      chk("good_pass_u3", d3_pass, 1);

      mode = 1;
      run_sweep(t1, t3);
      chk("model_s0_cnt", cum[0][LASTC], NC / 2);
      chk("model_s0_first", first[0], 1);
      chk("s0_err", d1_err, NC / 2);
      chk("s0_first", d1_ffc, 1);
      chk("s0_pass", d1_pass, 0);

      mode = 2;
      run_sweep(t1, t3);
      chk("model_ov_cnt", cum[1][LASTC], NC / 2);
      chk("ov_err", d3_err, NC / 2);
      chk("ov_first", d3_ffc, 9'h01F);

      repeat (4) @(negedge clk);
      mode = 3;
      run_sweep(t1, t3);
      chk("lag_pass_s3", d3_pass, 1);
      chk("lag_pass_s1", d1_pass, 0);

      for (int i = 0; i < 3; i++) begin
         mode  = 4;
         fcase = $urandom_range(0, LASTC);
         fmask = $urandom_range(1, (1 << (NB + 1)) - 1);
         run_sweep(t1, t3);
         chk("one_err_u1", d1_err, 1);
         chk("one_first_u3", d3_ffc, fcase);
      end

      mode = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat ($urandom_range(100, 900)) @(negedge clk);
      n_rst = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
      chk("abort_busy", d1_busy, 0);
      chk("abort_done", d3_done, 0);
      chk("abort_err", d3_err, 0);
      chk("abort_a", d1_a, 0);
      chk("abort_b", d3_b, 0);
      repeat (4) @(negedge clk);
      mode  = 4;
      fcase = $urandom_range(0, LASTC);
      run_sweep(t1, t3);
      chk("post_abort_err", d1_err, 1);

      mode = 0;
      @(negedge clk);
      start = 1'b1;
      n = 0;
      while (d1_done !== 1'b1 && n < TMO) begin
         @(negedge clk);
         n++;
      end
      chk("held_done", d1_done, 1);
      @(negedge clk);
      chk("held_restart_done", d1_done, 0);
      chk("held_restart_busy", d1_busy, 1);
      chk("held_restart_err", d1_err, 0);
      start = 1'b0;
      wait_done(t1, t3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
